// File: rtl/usb_epctl.sv
// USB endpoint controller: decides ACK/NAK/STALL replies for core transactions
// and keeps per-endpoint IN-armed, OUT-full and stall status.
module usb_epctl #(
    parameter int EP_NUM    = 3,
    parameter int REPLY_LAT = 1
) (
    input  logic              clk,
    input  logic              rst0_sync,
    input  logic [1:0]        trsac_req,
    input  logic [1:0]        trsac_type,
    input  logic [3:0]        trsac_ep,
    output logic [1:0]        trsac_reply,
    input  logic [EP_NUM-1:0] ep_enable,
    input  logic [EP_NUM-1:0] ep_isoch,
    input  logic [2:0]        app_cmd,
    input  logic [3:0]        app_ep,
    output logic              app_ack,
    output logic [EP_NUM:0]   ep_in_armed,
    output logic [EP_NUM:0]   ep_out_full,
    output logic [EP_NUM:0]   ep_stall,
    output logic              done_vld,
    output logic [3:0]        done_ep,
    output logic [1:0]        done_type,
    output logic              done_ok
);

    // state  | meaning
    // IDLE   | no transaction; reply NAK
    // DECIDE | transaction captured, counting REPLY_LAT cycles; reply NAK
    // WAIT   | decided reply held until the core leaves ACTIVE
    typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_WAIT} state_t;

    localparam logic [1:0] REQ_OK      = 2'd0;
    localparam logic [1:0] REQ_ACTIVE  = 2'd1;
    localparam logic [1:0] TYPE_SETUP  = 2'd0;
    localparam logic [1:0] TYPE_OUT    = 2'd1;
    localparam logic [1:0] TYPE_IN     = 2'd2;
    localparam logic [1:0] REPLY_ACK   = 2'd0;
    localparam logic [1:0] REPLY_NAK   = 2'd1;
    localparam logic [1:0] REPLY_STALL = 2'd2;
    localparam logic [2:0] CMD_ARM_IN  = 3'd1;
    localparam logic [2:0] CMD_REL_OUT = 3'd2;
    localparam logic [2:0] CMD_SET_STL = 3'd3;
    localparam logic [2:0] CMD_CLR_STL = 3'd4;

    state_t          state_q, state_d;
    logic [1:0]      req_prev_q;
    logic [1:0]      type_q;
    logic [3:0]      ep_q;
    logic [3:0]      lat_q;
    logic [1:0]      reply_q, reply_dec;
    logic [EP_NUM:0] armed_q, armed_d;
    logic [EP_NUM:0] full_q, full_d;
    logic [EP_NUM:0] stall_q, stall_d;
    logic            done_vld_q, done_ok_q;
    logic [3:0]      done_ep_q;
    logic [1:0]      done_type_q;

    logic            req_active, start;
    logic            capture, decide_fire, finish, complete_ok;
    logic            cmd_valid, cmd_exec;
    logic [EP_NUM:0] ep_oh, cmd_oh, en_vec, iso_vec;

    assign req_active = (trsac_req == REQ_ACTIVE);
    assign start      = req_active && (req_prev_q != REQ_ACTIVE);
    assign en_vec     = {ep_enable, 1'b1};
    assign iso_vec    = {ep_isoch, 1'b0};

    always_comb begin
        ep_oh  = '0;
        cmd_oh = '0;
        for (int i = 0; i <= EP_NUM; i++) begin
            ep_oh[i]  = (ep_q == 4'(i));
            cmd_oh[i] = (app_ep == 4'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst0_sync) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_DECIDE;
            S_DECIDE: begin
                if (!req_active)      state_d = S_IDLE;
                else if (lat_q == '0) state_d = S_WAIT;
            end
            S_WAIT:   if (!req_active) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Completion owns the status of its endpoint for this cycle; a command
    // aimed at it waits (no ack) and the application keeps presenting it.
    always_comb begin
        capture     = (state_q == S_IDLE) && start;
        decide_fire = (state_q == S_DECIDE) && req_active && (lat_q == '0);
        finish      = ((state_q == S_DECIDE) || (state_q == S_WAIT)) && !req_active;
        complete_ok = (state_q == S_WAIT) && (trsac_req == REQ_OK) && (reply_q == REPLY_ACK);
        cmd_valid   = (app_cmd >= CMD_ARM_IN) && (app_cmd <= CMD_CLR_STL);
        cmd_exec    = rst0_sync && cmd_valid && !(complete_ok && (app_ep == ep_q));
        app_ack     = cmd_exec;
    end

    always_comb begin
        reply_dec = REPLY_NAK;
        if (!(|ep_oh) || !(|(en_vec & ep_oh)))
            reply_dec = REPLY_STALL;
        else if (type_q == TYPE_SETUP)
            reply_dec = (ep_q == 4'd0) ? REPLY_ACK : REPLY_STALL;
        else if (|(stall_q & ep_oh))
            reply_dec = REPLY_STALL;
        else if (type_q == TYPE_IN)
            reply_dec = (|((armed_q | iso_vec) & ep_oh)) ? REPLY_ACK : REPLY_NAK;
        else if (type_q == TYPE_OUT)
            reply_dec = (|((~full_q | iso_vec) & ep_oh)) ? REPLY_ACK : REPLY_NAK;
        else
            reply_dec = REPLY_STALL;
    end

    always_comb begin
        armed_d = armed_q;
        full_d  = full_q;
        stall_d = stall_q;
        if (cmd_exec) begin
            case (app_cmd)
                CMD_ARM_IN:  armed_d = armed_q | cmd_oh;
                CMD_REL_OUT: full_d  = full_q & ~cmd_oh;
                CMD_SET_STL: stall_d = stall_q | cmd_oh;
                CMD_CLR_STL: stall_d = stall_q & ~cmd_oh;
                default: ;
            endcase
        end
        if (complete_ok) begin
            case (type_q)
                TYPE_IN:  armed_d = armed_d & ~ep_oh;
                TYPE_OUT: full_d  = full_d | ep_oh;
                TYPE_SETUP: begin
                    full_d[0]  = 1'b1;
                    stall_d[0] = 1'b0;
                    armed_d[0] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst0_sync) begin
            req_prev_q  <= REQ_ACTIVE;
            type_q      <= '0;
            ep_q        <= '0;
            lat_q       <= '0;
            reply_q     <= REPLY_NAK;
            armed_q     <= '0;
            full_q      <= '0;
            stall_q     <= '0;
            done_vld_q  <= 1'b0;
            done_ok_q   <= 1'b0;
            done_ep_q   <= '0;
            done_type_q <= '0;
        end else begin
            req_prev_q <= trsac_req;
            if (capture) begin
                type_q <= trsac_type;
                ep_q   <= trsac_ep;
                lat_q  <= 4'(REPLY_LAT - 1);
            end else if ((state_q == S_DECIDE) && (lat_q != '0)) begin
                lat_q <= lat_q - 4'd1;
            end
            if (decide_fire)            reply_q <= reply_dec;
            else if (state_d != S_WAIT) reply_q <= REPLY_NAK;
            armed_q    <= armed_d;
            full_q     <= full_d;
            stall_q    <= stall_d;
            done_vld_q <= finish;
            done_ok_q  <= finish && complete_ok;
            if (finish) begin
                done_ep_q   <= ep_q;
                done_type_q <= type_q;
            end
        end
    end

    assign trsac_reply = reply_q;
    assign ep_in_armed = armed_q;
    assign ep_out_full = full_q;
    assign ep_stall    = stall_q;
    assign done_vld    = done_vld_q;
    assign done_ep     = done_ep_q;
    assign done_type   = done_type_q;
    assign done_ok     = done_ok_q;

endmodule

// File: tb/tb_usb_epctl.sv
// Randomised scoreboard bench for usb_epctl against a rule-level endpoint model.
module tb_usb_epctl;

    localparam int EP_NUM = 3;
    localparam int LAT    = 1;

    localparam logic [1:0] OK = 2'd0, ACTIVE = 2'd1, FAILR = 2'd2;
    localparam logic [1:0] SETUP = 2'd0, OUTT = 2'd1, INT = 2'd2;
    localparam logic [1:0] ACK = 2'd0, NAK = 2'd1, STALL = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst0_sync;
    logic [1:0]        trsac_req, trsac_type;
    logic [3:0]        trsac_ep;
    logic [1:0]        trsac_reply;
    logic [EP_NUM-1:0] ep_enable, ep_isoch;
    logic [2:0]        app_cmd;
    logic [3:0]        app_ep;
    logic              app_ack;
    logic [EP_NUM:0]   ep_in_armed, ep_out_full, ep_stall;
    logic              done_vld;
    logic [3:0]        done_ep;
    logic [1:0]        done_type;
    logic              done_ok;

    usb_epctl #(.EP_NUM(EP_NUM), .REPLY_LAT(LAT)) dut (
        .clk(clk), .rst0_sync(rst0_sync),
        .trsac_req(trsac_req), .trsac_type(trsac_type), .trsac_ep(trsac_ep),
        .trsac_reply(trsac_reply),
        .ep_enable(ep_enable), .ep_isoch(ep_isoch),
        .app_cmd(app_cmd), .app_ep(app_ep), .app_ack(app_ack),
        .ep_in_armed(ep_in_armed), .ep_out_full(ep_out_full), .ep_stall(ep_stall),
        .done_vld(done_vld), .done_ep(done_ep), .done_type(done_type), .done_ok(done_ok)
    );

    typedef struct {logic [3:0] ep; logic [1:0] ty; logic ok;} done_t;
    done_t sbq[$];

    int n_vec = 0;
    int n_err = 0;

    bit m_arm[16], m_full[16], m_stall[16], m_en[16], m_iso[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [EP_NUM:0] vec(input bit a[16]);
        logic [EP_NUM:0] r;
        for (int i = 0; i <= EP_NUM; i++) r[i] = a[i];
        return r;
    endfunction

    // Reply rules in priority order, evaluated on the model state.
    function automatic logic [1:0] model_reply(input logic [1:0] ty, input logic [3:0] ep);
        if (int'(ep) > EP_NUM) return STALL;
        if (ep != 0 && !m_en[ep]) return STALL;
        if (ty == SETUP) return (ep == 0) ? ACK : STALL;
        if (m_stall[ep]) return STALL;
        if (ty == INT) return (m_arm[ep] || m_iso[ep]) ? ACK : NAK;
        return (!m_full[ep] || m_iso[ep]) ? ACK : NAK;
    endfunction

    task automatic drive_cfg();
        for (int i = 1; i <= EP_NUM; i++) begin
            ep_enable[i-1] = m_en[i];
            ep_isoch[i-1]  = m_iso[i];
        end
    endtask

    task automatic check_status();
        chk("ep_in_armed", 32'(ep_in_armed), 32'(vec(m_arm)));
        chk("ep_out_full", 32'(ep_out_full), 32'(vec(m_full)));
        chk("ep_stall",    32'(ep_stall),    32'(vec(m_stall)));
    endtask

    task automatic model_cmd(input logic [2:0] c, input logic [3:0] ep);
        if (int'(ep) <= EP_NUM) begin
            case (c)
                3'd1: m_arm[ep]   = 1'b1;
                3'd2: m_full[ep]  = 1'b0;
                3'd3: m_stall[ep] = 1'b1;
                3'd4: m_stall[ep] = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [3:0] ep);
        @(negedge clk);
        app_cmd = c;
        app_ep  = ep;
        #1;
        chk("app_ack", 32'(app_ack), 32'd1);
        model_cmd(c, ep);
        @(negedge clk);
        app_cmd = 3'd0;
        #1;
        chk("app_ack_idle", 32'(app_ack), 32'd0);
        check_status();
    endtask

    task automatic do_trans(input logic [1:0] ty, input logic [3:0] ep, input bit abort,
                            input logic [1:0] fin, input int hold, input bit conc);
        logic [1:0] exp;
        bit ok;
        done_t d;
        @(negedge clk);
        trsac_type = ty;
        trsac_ep   = ep;
        trsac_req  = ACTIVE;
        exp = model_reply(ty, ep);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            chk("reply_decide", 32'(trsac_reply), 32'(NAK));
            if (abort) begin
                trsac_req = fin;
                d.ep = ep; d.ty = ty; d.ok = 1'b0;
                sbq.push_back(d);
                @(negedge clk);
                chk("reply_abort", 32'(trsac_reply), 32'(NAK));
                check_status();
                return;
            end
        end
        @(negedge clk);
        chk("reply", 32'(trsac_reply), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("reply_hold", 32'(trsac_reply), 32'(exp));
        end
        trsac_req = fin;
        ok = (fin == OK) && (exp == ACK);
        d.ep = ep; d.ty = ty; d.ok = ok;
        sbq.push_back(d);
        if (ok) begin
            case (ty)
                INT:   m_arm[ep]  = 1'b0;
                OUTT:  m_full[ep] = 1'b1;
                SETUP: begin m_full[0] = 1'b1; m_stall[0] = 1'b0; m_arm[0] = 1'b0; end
                default: ;
            endcase
        end
        if (conc) begin
            app_cmd = 3'd1;
            app_ep  = ep;
            #1;
            chk("ack_collide", 32'(app_ack), ok ? 32'd0 : 32'd1);
            @(negedge clk);
            if (ok) begin
                #1;
                chk("ack_retry", 32'(app_ack), 32'd1);
                @(negedge clk);
            end
            app_cmd = 3'd0;
            model_cmd(3'd1, ep);
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk("reply_idle", 32'(trsac_reply), 32'(NAK));
        check_status();
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    initial begin
        done_t e;
        forever begin
            @(negedge clk);
            if (done_vld === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_ep",   32'(done_ep),   32'(e.ep));
                    chk("done_type", 32'(done_type), 32'(e.ty));
                    chk("done_ok",   32'(done_ok),   32'(e.ok));
                end
            end
        end
    end

    initial begin
        rst0_sync  = 1'b0;
        trsac_req  = OK;
        trsac_type = SETUP;
        trsac_ep   = 4'd0;
        app_cmd    = 3'd1;
        app_ep     = 4'd1;
        for (int i = 0; i < 16; i++) begin
            m_arm[i] = 0; m_full[i] = 0; m_stall[i] = 0; m_iso[i] = 0;
            m_en[i] = 1;
        end
        drive_cfg();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_reply", 32'(trsac_reply), 32'(NAK));
        chk("rst_ack",   32'(app_ack), 32'd0);
        chk("rst_done",  32'({done_vld, done_ok, done_ep, done_type}), 32'd0);
        check_status();
        @(negedge clk);
        app_cmd   = 3'd0;
        rst0_sync = 1'b1;

        cmd(3'd1, 4'd2);
        do_trans(INT, 4'd2, 0, OK, 1, 0);

        do_trans(OUTT, 4'd1, 0, OK, 0, 0);
        do_trans(OUTT, 4'd1, 0, OK, 0, 0);
        cmd(3'd2, 4'd1);
        do_trans(OUTT, 4'd1, 0, OK, 0, 0);

        cmd(3'd3, 4'd0);
        do_trans(SETUP, 4'd0, 0, OK, 2, 0);
        do_trans(INT, 4'd5, 0, OK, 0, 0);
        cmd(3'd3, 4'd1);
        do_trans(OUTT, 4'd1, 0, OK, 0, 0);
        cmd(3'd4, 4'd1);

        m_iso[3] = 1; drive_cfg();
        do_trans(INT, 4'd3, 0, OK, 0, 0);
        do_trans(OUTT, 4'd3, 0, OK, 0, 0);
        do_trans(OUTT, 4'd3, 0, OK, 0, 0);
        m_en[3] = 0; drive_cfg();
        do_trans(INT, 4'd3, 0, OK, 0, 0);
        m_en[3] = 1; m_iso[3] = 0; drive_cfg();

        cmd(3'd1, 4'd2);
        do_trans(INT, 4'd2, 0, OK, 0, 1);

        cmd(3'd1, 4'd1);
        do_trans(INT, 4'd1, 1, OK, 0, 0);
        do_trans(INT, 4'd1, 0, FAILR, 1, 0);
        cmd(3'd3, 4'd7);

        // Reset in WAIT with the request held ACTIVE through release.
        @(negedge clk);
        trsac_type = INT; trsac_ep = 4'd1; trsac_req = ACTIVE;
        repeat (LAT + 1) @(negedge clk);
        rst0_sync = 1'b0;
        repeat (2) @(negedge clk);
        rst0_sync = 1'b1;
        for (int i = 0; i < 16; i++) begin m_arm[i] = 0; m_full[i] = 0; m_stall[i] = 0; end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reply_post_rst", 32'(trsac_reply), 32'(NAK));
        end
        trsac_req = OK;
        repeat (3) @(negedge clk);
        check_status();
        do_trans(OUTT, 4'd2, 0, OK, 0, 0);

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 1; i <= EP_NUM; i++) begin
                    m_en[i]  = ($urandom_range(0, 5) != 0);
                    m_iso[i] = ($urandom_range(0, 4) == 0);
                end
                drive_cfg();
            end
            if ($urandom_range(0, 2) == 0) begin
                cmd(3'($urandom_range(1, 4)), 4'($urandom_range(0, 4)));
            end else begin
                do_trans(2'($urandom_range(0, 2)), 4'($urandom_range(0, 4)),
                         ($urandom_range(0, 9) == 0),
                         ($urandom_range(0, 4) == 0) ? FAILR : OK,
                         $urandom_range(0, 3), ($urandom_range(0, 6) == 0));
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_epctl.md
USB_EPCTL -- requirements
Module: usb_epctl

Interface
REQ-001 The block SHALL have parameter EP_NUM, default 3, giving the highest endpoint number served (1..15); endpoint 0 is always present.
REQ-002 The block SHALL have parameter REPLY_LAT, default 1, giving the cycles from transaction start to a decided reply (1..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst0_sync  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port trsac_req  input  2  transaction state from the USB core: 0 OK, 1 ACTIVE, 2 FAIL.
REQ-006 The block SHALL have port trsac_type  input  2  transaction type: 0 SETUP, 1 OUT, 2 IN.
REQ-007 The block SHALL have port trsac_ep  input  4  endpoint number of the transaction.
REQ-008 The block SHALL have port trsac_reply  output  2  reply to the core: 0 ACK, 1 NAK, 2 STALL.
REQ-009 The block SHALL have port ep_enable  input  EP_NUM  enable for endpoints EP_NUM..1.
REQ-010 The block SHALL have port ep_isoch  input  EP_NUM  isochronous flag for endpoints EP_NUM..1.
REQ-011 The block SHALL have port app_cmd  input  3  command: 0 none, 1 ARM_IN, 2 RELEASE_OUT, 3 SET_STALL, 4 CLR_STALL.
REQ-012 The block SHALL have port app_ep  input  4  target endpoint of app_cmd.
REQ-013 The block SHALL have port app_ack  output  1  one-cycle pulse when app_cmd is executed.
REQ-014 The block SHALL have ports ep_in_armed, ep_out_full, ep_stall  output  EP_NUM+1 each  per-endpoint status.
REQ-015 The block SHALL have ports done_vld (1), done_ep (4), done_type (2), done_ok (1)  output  transaction completion report.

Function
REQ-016 A transaction SHALL start only on a cycle where trsac_req==ACTIVE and the previous cycle's trsac_req!=ACTIVE; trsac_type and trsac_ep are captured on that cycle.
REQ-017 The FSM SHALL have states IDLE, DECIDE and WAIT: IDLE->DECIDE on start; DECIDE->WAIT after REPLY_LAT cycles; WAIT->IDLE when trsac_req!=ACTIVE.
REQ-018 trsac_reply SHALL read NAK in IDLE and DECIDE; the decided reply SHALL be registered exactly REPLY_LAT cycles after the start cycle and held through WAIT.
REQ-019 If trsac_req leaves ACTIVE while in DECIDE, the FSM SHALL go to IDLE, report done_ok=0, and change no endpoint state.
REQ-020 Reply decision, highest priority first:
  - ep>EP_NUM, or ep!=0 with ep_enable clear -> STALL
  - SETUP on ep0 -> ACK (ignores stall and full)
  - SETUP on ep!=0 -> STALL
  - ep_stall set -> STALL
  - IN: armed -> ACK; otherwise NAK, or ACK when isochronous
  - OUT: not full -> ACK; otherwise NAK, or ACK when isochronous
REQ-021 Status SHALL be taken at decision time; app commands executed after the decision SHALL NOT alter that reply.
REQ-022 On leaving WAIT with trsac_req==OK and reply ACK, the block SHALL update endpoint state:
  - IN: clear ep_in_armed
  - OUT: set ep_out_full
  - SETUP: set ep_out_full[0], clear ep_stall[0] and ep_in_armed[0]
REQ-023 On leaving WAIT with FAIL, or with any reply other than ACK, endpoint state SHALL be unchanged.
REQ-024 Isochronous OUT ACK SHALL be issued while full, and ep_out_full SHALL stay set.
REQ-025 done_vld SHALL pulse for one cycle on every WAIT->IDLE and every DECIDE->IDLE transition, with done_ep and done_type equal to the captured values and done_ok=1 only for OK completion with ACK.
REQ-026 Commands SHALL act as follows:
  - ARM_IN sets ep_in_armed
  - RELEASE_OUT clears ep_out_full
  - SET_STALL sets ep_stall
  - CLR_STALL clears ep_stall
REQ-027 app_ack SHALL pulse in the execution cycle, and status SHALL change on the following edge.
REQ-028 If a command targets the endpoint being updated by completion in the same cycle, the completion SHALL apply, app_ack SHALL stay 0, and the application SHALL hold the command until it is acknowledged.
REQ-029 A command with app_ep>EP_NUM SHALL be acknowledged with no effect.
REQ-030 Any number of endpoints may have status bits set simultaneously; status bits SHALL be independent per endpoint.

Reset
REQ-031 While rst0_sync==0 at a clock edge, the block SHALL set:
  - FSM to IDLE
  - trsac_reply to NAK
  - all status vectors to 0
  - app_ack, done_vld, done_ok to 0
  - done_ep, done_type to 0
REQ-032 The previous-request register SHALL reset to ACTIVE, so that a request already ACTIVE across reset release is not treated as a new transaction.
REQ-033 Reset during DECIDE or WAIT SHALL abandon the transaction without a done_vld pulse.

Verification
REQ-034 ARM_IN on ep2, then IN on ep2 with REPLY_LAT=1 -> trsac_reply=ACK one cycle after start; OK completion -> ep_in_armed[2]=0 and done_ok=1.
REQ-035 OUT on ep1 twice with no RELEASE_OUT in between -> first ACK and ep_out_full[1]=1; second NAK; after RELEASE_OUT, a third OUT -> ACK.
REQ-036 SET_STALL ep0, then SETUP on ep0 -> ACK, and on OK completion ep_stall[0]=0 and ep_out_full[0]=1; IN on ep5 with EP_NUM=3 -> STALL.
REQ-037 Isochronous ep3 receives IN with nothing armed -> ACK; ep3 disabled -> STALL.
REQ-038 ARM_IN ep2 issued in the same cycle as the OK completion of an ep2 IN -> app_ack=0 that cycle, ack on the next cycle, and final ep_in_armed[2]=1.
REQ-039 Reset asserted during WAIT with trsac_req held ACTIVE through reset release -> no reply other than NAK and no done_vld until trsac_req drops and rises again.
